multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Control FSM that sequences the RV32I multicycle datapath through the FETCH, DECODE, EXEC, MEM and WB states.
- Holds the instruction register (IR). The IR feeds the immediate generator, the register-file address fields and this block's own decode.
- Drives every datapath mux select and write strobe, and handshakes with instruction and data memories that may insert wait states.

Parameters:
- RESET_IR, 32'h0000_0013, IR value at reset (ADDI x0,x0,0 NOP).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_instr  in  32  instruction memory read data, valid when i_imem_ready=1
- i_imem_ready  in  1  instruction fetch complete
- i_dmem_ready  in  1  data access complete
- i_br_equal  in  1  branch comparator: rs1==rs2
- i_br_less  in  1  branch comparator: rs1<rs2 (unsigned when o_br_un=1)
- o_ir  out  32  latched instruction register
- o_imem_req  out  1  fetch request
- o_pc_we  out  1  PC write enable
- o_pc_sel  out  2  0 = PC+4, 1 = ALUOut register, 2 = ALU result (combinational)
- o_alu_a_sel  out  1  0 = rs1, 1 = PC
- o_alu_b_sel  out  1  0 = rs2, 1 = immediate
- o_alu_op  out  4  alu_op_e
- o_aluout_we  out  1  ALUOut register enable
- o_br_un  out  1  unsigned compare
- o_dmem_req  out  1  data access request
- o_dmem_we  out  1  data store
- o_mdr_we  out  1  memory data register enable
- o_rd_wren  out  1  register-file write
- o_wb_sel  out  2  0 = ALUOut, 1 = MDR, 2 = PC+4
- o_insn_vld  out  1  one-cycle pulse on instruction retire
- o_illegal  out  1  one-cycle pulse on illegal instruction
- o_state  out  3  current state (debug)

Behaviour:
- Reset (asynchronous): state = FETCH, IR = RESET_IR. While i_reset=1 every output strobe/request is 0 and all selects are 0.
- Outputs are combinational from state, IR and the ready inputs.
- FETCH:
  - o_imem_req=1, held until i_imem_ready=1.
  - On ready: IR <= i_instr, go to DECODE. Otherwise stay.
- DECODE:
  - Checks legality. Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Also illegal: branch funct3 010/011; load funct3 011/110/111; store funct3 >=011.
  - Illegal: o_illegal=1, o_pc_we=1, o_pc_sel=0, no retire, go to FETCH.
  - Legal: go to EXEC.
- EXEC: o_aluout_we=1 for every class except branch.
  - R-type: a=rs1, b=rs2, op from {funct7[5],funct3}.
  - I-ALU: b=imm, op from funct3; funct7[5] is honoured only for funct3=101 (SRAI).
  - LUI: op=COPY_B, b=imm.
  - AUIPC and JAL: a=PC, b=imm, ADD.
  - JALR, load and store: a=rs1, b=imm, ADD. The datapath clears bit 0 of the JALR target.
  - Next state: load/store go to MEM; branch goes to FETCH; all others go to WB.
- Branch in EXEC:
  - a=PC, b=imm, ADD; o_br_un=funct3[1].
  - Taken: BEQ equal, BNE !equal, BLT/BLTU less, BGE/BGEU !less.
  - o_pc_we=1, o_pc_sel = taken ? 2 : 0, o_insn_vld=1.
- MEM:
  - o_dmem_req=1, held until i_dmem_ready=1. o_dmem_we = store.
  - Store on ready: o_pc_we=1 (sel 0), o_insn_vld=1, go to FETCH.
  - Load on ready: o_mdr_we=1, go to WB.
- WB:
  - o_rd_wren = (rd != 0).
  - o_wb_sel: 1 for load, 2 for JAL/JALR, else 0.
  - o_pc_we=1; o_pc_sel = 1 for JAL/JALR, else 0.
  - o_insn_vld=1, go to FETCH.
- Latency with zero-wait memories:
  - branch 3 cycles
  - ALU/LUI/AUIPC/JAL/JALR and store 4 cycles
  - load 5 cycles
  - illegal 2 cycles
  - each memory wait cycle adds 1
- Ready inputs are ignored outside the state that owns the matching request.
- Reset mid-operation: any pending request is dropped immediately, no write strobe is issued, and the FSM restarts in FETCH.

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode localparams
  - state_e {FETCH, DECODE, EXEC, MEM, WB}
  - alu_op_e {ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, COPY_B}
  - pc_sel_e
  - wb_sel_e
- Sub-module ctrl_decode: pure combinational IR -> instruction class, legality, alu_op.

Test Plan:
- Reset release, i_instr=0x00500093 (ADDI x1,x0,5), zero-wait memory:
  - Requires FETCH->DECODE->EXEC->WB.
  - EXEC: b_sel=1, op=ADD.
  - Cycle 4: rd_wren=1, wb_sel=0, pc_we=1, pc_sel=0, insn_vld=1.
- 0x00208463 (BEQ x1,x2,8) with i_br_equal=1:
  - EXEC: pc_we=1, pc_sel=2, insn_vld=1, rd_wren=0.
  - Repeat with i_br_equal=0 -> pc_sel=0.
- 0x0000A183 (LW x3,0(x1)) with i_dmem_ready asserted on the 4th MEM cycle:
  - dmem_req high 4 cycles, dmem_we=0.
  - mdr_we on the ready cycle.
  - WB: wb_sel=1, rd_wren=1; 8 cycles total.
- 0xFFFFFFFF:
  - DECODE: illegal=1, pc_we=1, pc_sel=0, insn_vld=0, then FETCH.
  - Also 0x00000013 (ADDI x0) reaches WB with rd_wren=0.
- 0x010000EF (JAL x1,16):
  - EXEC: a_sel=1, b_sel=1, aluout_we=1.
  - WB: wb_sel=2, rd_wren=1, pc_sel=1.
- i_reset pulsed during MEM while dmem_req=1:
  - dmem_req falls combinationally, with no pc_we, rd_wren or insn_vld.
  - o_ir=0x00000013 and o_state=FETCH after release.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared types and constants for the RV32I multicycle control FSM.
package rv_ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    ADD    = 4'd0,
    SUB    = 4'd1,
    SLL    = 4'd2,
    SLT    = 4'd3,
    SLTU   = 4'd4,
    XOR    = 4'd5,
    SRL    = 4'd6,
    SRA    = 4'd7,
    OR     = 4'd8,
    AND    = 4'd9,
    COPY_B = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    PcPlus4  = 2'd0,
    PcAluOut = 2'd1,
    PcAlu    = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    WbAluOut = 2'd0,
    WbMdr    = 2'd1,
    WbPc4    = 2'd2
  } wb_sel_e;

  typedef enum logic [3:0] {
    ClsOp     = 4'd0,
    ClsOpImm  = 4'd1,
    ClsLoad   = 4'd2,
    ClsStore  = 4'd3,
    ClsBranch = 4'd4,
    ClsJal    = 4'd5,
    ClsJalr   = 4'd6,
    ClsLui    = 4'd7,
    ClsAuipc  = 4'd8
  } insn_cls_e;

  // alt selects SUB/SRA for funct3 000/101; callers decide when alt is meaningful.
  function automatic alu_op_e alu_op_from(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? SUB : ADD;
      3'b001:  op = SLL;
      3'b010:  op = SLT;
      3'b011:  op = SLTU;
      3'b100:  op = XOR;
      3'b101:  op = alt ? SRA : SRL;
      3'b110:  op = OR;
      default: op = AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decode: class, legality and ALU operation.
module ctrl_decode
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7_5,
  output logic [3:0] o_cls,
  output logic       o_legal,
  output logic [3:0] o_alu_op
);

  // Classify opcode, reject reserved funct3 encodings, pick ALU op.
  always_comb begin
    o_cls    = ClsOp;
    o_legal  = 1'b1;
    o_alu_op = ADD;
    case (i_opcode)
      OPC_OP: begin
        o_cls    = ClsOp;
        o_alu_op = alu_op_from(i_funct3, i_funct7_5);
      end
      OPC_OP_IMM: begin
        o_cls    = ClsOpImm;
        // Bit 30 is immediate data except for SRAI.
        o_alu_op = alu_op_from(i_funct3, (i_funct3 == 3'b101) && i_funct7_5);
      end
      OPC_LOAD: begin
        o_cls   = ClsLoad;
        o_legal = !((i_funct3 == 3'b011) || (i_funct3 == 3'b110) || (i_funct3 == 3'b111));
      end
      OPC_STORE: begin
        o_cls   = ClsStore;
        o_legal = (i_funct3 < 3'b011);
      end
      OPC_BRANCH: begin
        o_cls   = ClsBranch;
        o_legal = !((i_funct3 == 3'b010) || (i_funct3 == 3'b011));
      end
      OPC_JAL:   o_cls = ClsJal;
      OPC_JALR:  o_cls = ClsJalr;
      OPC_LUI: begin
        o_cls    = ClsLui;
        o_alu_op = COPY_B;
      end
      OPC_AUIPC: o_cls = ClsAuipc;
      default:   o_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the RV32I multicycle datapath; owns the instruction register.
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_IR = 32'h0000_0013
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [31:0] i_instr,
  input  logic        i_imem_ready,
  input  logic        i_dmem_ready,
  input  logic        i_br_equal,
  input  logic        i_br_less,
  output logic [31:0] o_ir,
  output logic        o_imem_req,
  output logic        o_pc_we,
  output logic [1:0]  o_pc_sel,
  output logic        o_alu_a_sel,
  output logic        o_alu_b_sel,
  output logic [3:0]  o_alu_op,
  output logic        o_aluout_we,
  output logic        o_br_un,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic        o_mdr_we,
  output logic        o_rd_wren,
  output logic [1:0]  o_wb_sel,
  output logic        o_insn_vld,
  output logic        o_illegal,
  output logic [2:0]  o_state
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [3:0]  cls;
  logic        legal;
  logic [3:0]  alu_op;
  logic        is_load, is_store, is_branch, is_jump, taken;
  logic [2:0]  funct3;

  ctrl_decode u_decode (
    .i_opcode   (ir_q[6:0]),
    .i_funct3   (ir_q[14:12]),
    .i_funct7_5 (ir_q[30]),
    .o_cls      (cls),
    .o_legal    (legal),
    .o_alu_op   (alu_op)
  );

  assign funct3    = ir_q[14:12];
  assign is_load   = (cls == ClsLoad);
  assign is_store  = (cls == ClsStore);
  assign is_branch = (cls == ClsBranch);
  assign is_jump   = (cls == ClsJal) || (cls == ClsJalr);

  // Branch resolution from the external comparator.
  always_comb begin
    case (funct3)
      3'b000:         taken = i_br_equal;
      3'b001:         taken = !i_br_equal;
      3'b100, 3'b110: taken = i_br_less;
      3'b101, 3'b111: taken = !i_br_less;
      default:        taken = 1'b0;
    endcase
  end

  // Next state and all datapath controls; everything is forced idle while in reset.
  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    o_imem_req  = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_sel    = PcPlus4;
    o_alu_a_sel = 1'b0;
    o_alu_b_sel = 1'b0;
    o_alu_op    = ADD;
    o_aluout_we = 1'b0;
    o_br_un     = 1'b0;
    o_dmem_req  = 1'b0;
    o_dmem_we   = 1'b0;
    o_mdr_we    = 1'b0;
    o_rd_wren   = 1'b0;
    o_wb_sel    = WbAluOut;
    o_insn_vld  = 1'b0;
    o_illegal   = 1'b0;
    if (!i_reset) begin
      case (state_q)
        FETCH: begin
          o_imem_req = 1'b1;
          if (i_imem_ready) begin
            ir_d    = i_instr;
            state_d = DECODE;
          end
        end
        DECODE: begin
          if (!legal) begin
            o_illegal = 1'b1;
            o_pc_we   = 1'b1;
            state_d   = FETCH;
          end else begin
            state_d = EXEC;
          end
        end
        EXEC: begin
          o_alu_op    = alu_op;
          o_alu_b_sel = (cls != ClsOp);
          o_alu_a_sel = (cls == ClsAuipc) || (cls == ClsJal) || is_branch;
          if (is_branch) begin
            o_br_un    = funct3[1];
            o_pc_we    = 1'b1;
            o_pc_sel   = taken ? PcAlu : PcPlus4;
            o_insn_vld = 1'b1;
            state_d    = FETCH;
          end else begin
            o_aluout_we = 1'b1;
            state_d     = (is_load || is_store) ? MEM : WB;
          end
        end
        MEM: begin
          o_dmem_req = 1'b1;
          o_dmem_we  = is_store;
          if (i_dmem_ready) begin
            if (is_store) begin
              o_pc_we    = 1'b1;
              o_insn_vld = 1'b1;
              state_d    = FETCH;
            end else begin
              o_mdr_we = 1'b1;
              state_d  = WB;
            end
          end
        end
        WB: begin
          o_rd_wren  = (ir_q[11:7] != 5'd0);
          o_wb_sel   = is_load ? WbMdr : (is_jump ? WbPc4 : WbAluOut);
          o_pc_we    = 1'b1;
          o_pc_sel   = is_jump ? PcAluOut : PcPlus4;
          o_insn_vld = 1'b1;
          state_d    = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and instruction register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= FETCH;
      ir_q    <= RESET_IR;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign o_ir    = ir_q;
  assign o_state = state_q;

endmodule
